// File: rtl/tlul_dma_copy.sv
// TL-UL type definitions, command integrity generator and the block-copy host.
// Latency: 4 cycles per word against a zero-wait device with one-cycle response, plus 1 FIN cycle.
// Backpressure: a_valid and all A fields hold until a_ready; d_ready is high only while awaiting a response.

package tlul_pkg;

    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 1;
    localparam int TL_DBW = 4;
    localparam int TL_SZW = 2;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic [6:0] cmd_intg;
        logic [6:0] data_intg;
    } tl_a_user_t;

    typedef struct packed {
        logic [6:0] rsp_intg;
        logic [6:0] data_intg;
    } tl_d_user_t;

    typedef struct packed {
        logic                a_valid;
        tl_a_op_e            a_opcode;
        logic [2:0]          a_param;
        logic [TL_SZW-1:0]   a_size;
        logic [TL_AIW-1:0]   a_source;
        logic [TL_AW-1:0]    a_address;
        logic [TL_DBW-1:0]   a_mask;
        logic [TL_DW-1:0]    a_data;
        tl_a_user_t          a_user;
        logic                d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic                d_valid;
        tl_d_op_e            d_opcode;
        logic [2:0]          d_param;
        logic [TL_SZW-1:0]   d_size;
        logic [TL_AIW-1:0]   d_source;
        logic [TL_DIW-1:0]   d_sink;
        logic [TL_DW-1:0]    d_data;
        tl_d_user_t          d_user;
        logic                d_error;
        logic                a_ready;
    } tl_d2h_t;

endpackage

// Fills a_user with check bits over the command fields and the write data.
// Latency: purely combinational.
// Backpressure: none; every field other than a_user passes straight through.
module tlul_cmd_intg_gen
    import tlul_pkg::*;
(
    input  tl_h2d_t tl_i,
    output tl_h2d_t tl_o
);

    // Hamming-style check: input bit j contributes to check bit i when bit i of (j+1) is set.
    function automatic logic [6:0] hamming7(input logic [63:0] v);
        logic [6:0] p;
        p = '0;
        for (int j = 0; j < 64; j++) begin
            for (int i = 0; i < 7; i++) begin
                if ((((j + 1) >> i) & 1) != 0) begin
                    p[i] = p[i] ^ v[j];
                end
            end
        end
        return p;
    endfunction

    // Pass the request through and overwrite only the integrity field.
    always_comb begin
        tl_o                  = tl_i;
        tl_o.a_user.cmd_intg  = hamming7({25'd0, tl_i.a_opcode, tl_i.a_address, tl_i.a_mask});
        tl_o.a_user.data_intg = hamming7({32'd0, tl_i.a_data});
    end

endmodule

// Copies len_words_i 32-bit words from src to dst, one Get then one PutFullData at a time.
// Latency: 4 cycles per word with a zero-wait one-cycle-response device, plus 1 cycle in FIN.
// Backpressure: stalls in RD_REQ/WR_REQ with fields held while a_ready is low; waits indefinitely for d_valid.
module tlul_dma_copy
    import tlul_pkg::*;
#(
    parameter logic [TL_AIW-1:0] SourceId = '0,
    parameter int                LenW     = 12
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [31:0]     src_addr_i,
    input  logic [31:0]     dst_addr_i,
    input  logic [LenW-1:0] len_words_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o,
    output tl_h2d_t         tl_o,
    input  tl_d2h_t         tl_i
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_REQ = 3'd1,
        RD_RSP = 3'd2,
        WR_REQ = 3'd3,
        WR_RSP = 3'd4,
        FIN    = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     src_q;
    logic [31:0]     dst_q;
    logic [LenW-1:0] rem_q;
    logic [31:0]     data_q;
    logic            err_q;

    logic            misaligned;
    logic            rd_rsp_ok;
    logic            wr_rsp_ok;
    tl_h2d_t         req_raw;

    assign misaligned = (src_addr_i[1:0] != 2'b00) || (dst_addr_i[1:0] != 2'b00);
    assign rd_rsp_ok  = !tl_i.d_error && (tl_i.d_opcode == AccessAckData);
    assign wr_rsp_ok  = !tl_i.d_error && (tl_i.d_opcode == AccessAck);

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and the A/D channel controls for the current state.
    always_comb begin
        state_d           = state_q;
        req_raw           = '0;
        req_raw.a_opcode  = Get;
        req_raw.a_size    = 2'd2;
        req_raw.a_mask    = 4'hF;
        req_raw.a_source  = SourceId;
        req_raw.a_address = src_q;
        done_o            = 1'b0;
        busy_o            = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (misaligned || (len_words_i == '0)) begin
                        state_d = FIN;
                    end else begin
                        state_d = RD_REQ;
                    end
                end
            end
            RD_REQ: begin
                busy_o          = 1'b1;
                req_raw.a_valid = 1'b1;
                if (tl_i.a_ready) begin
                    state_d = RD_RSP;
                end
            end
            RD_RSP: begin
                busy_o          = 1'b1;
                req_raw.d_ready = 1'b1;
                if (tl_i.d_valid) begin
                    state_d = rd_rsp_ok ? WR_REQ : FIN;
                end
            end
            WR_REQ: begin
                busy_o            = 1'b1;
                req_raw.a_valid   = 1'b1;
                req_raw.a_opcode  = PutFullData;
                req_raw.a_address = dst_q;
                req_raw.a_data    = data_q;
                if (tl_i.a_ready) begin
                    state_d = WR_RSP;
                end
            end
            WR_RSP: begin
                busy_o          = 1'b1;
                req_raw.d_ready = 1'b1;
                if (tl_i.d_valid) begin
                    if (!wr_rsp_ok || (rem_q == LenW'(1))) begin
                        state_d = FIN;
                    end else begin
                        state_d = RD_REQ;
                    end
                end
            end
            FIN: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Address, count, data and error registers, updated on start and on each accepted response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_q  <= '0;
            dst_q  <= '0;
            rem_q  <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        src_q <= src_addr_i;
                        dst_q <= dst_addr_i;
                        rem_q <= len_words_i;
                        err_q <= misaligned;
                    end
                end
                RD_RSP: begin
                    if (tl_i.d_valid) begin
                        if (rd_rsp_ok) begin
                            data_q <= tl_i.d_data;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                WR_RSP: begin
                    if (tl_i.d_valid) begin
                        if (wr_rsp_ok) begin
                            // Wraps modulo 2^32 by construction.
                            src_q <= src_q + 32'd4;
                            dst_q <= dst_q + 32'd4;
                            rem_q <= rem_q - LenW'(1);
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign err_o = err_q;

    tlul_cmd_intg_gen u_cmd_intg (
        .tl_i (req_raw),
        .tl_o (tl_o)
    );

    // Response fields this host has no use for; integrity is checked upstream in the xbar.
    logic unused_rsp;
    assign unused_rsp = ^{tl_i.d_param, tl_i.d_size, tl_i.d_source, tl_i.d_sink, tl_i.d_user};

endmodule
